// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX stage: control bundle layout, bubble encoding,
// decoder opcodes and the "instruction reads rt" predicate.
package id_ex_pipe_pkg;

    localparam int unsigned CTRL_W = 10;

    localparam int unsigned CTRL_REG_DST    = 9;
    localparam int unsigned CTRL_MEM_TO_REG = 8;
    localparam int unsigned CTRL_ALU_OP_HI  = 7;
    localparam int unsigned CTRL_ALU_OP_LO  = 6;
    localparam int unsigned CTRL_MEM_READ   = 5;
    localparam int unsigned CTRL_MEM_WRITE  = 4;
    localparam int unsigned CTRL_ALU_SRC    = 3;
    localparam int unsigned CTRL_REG_WRITE  = 2;
    localparam int unsigned CTRL_BRANCH     = 1;
    localparam int unsigned CTRL_JUMP       = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 10'b0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // rt is a source operand for R-type (reg_dst), stores and branches.
    function automatic logic uses_rt(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_REG_DST] | ctrl[CTRL_MEM_WRITE] | ctrl[CTRL_BRANCH];
    endfunction

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use hazard detection and front-end (PC, IF/ID) write enables.
module id_ex_pipe_hazard_detect #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  id_valid,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  flush,
    input  logic                  hold,
    output logic                  lu,
    output logic                  pc_write,
    output logic                  if_id_write
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match    = (ex_rt == id_rs);
        rt_match    = (ex_rt == id_rt) & id_uses_rt;
        lu          = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid & (rs_match | rt_match);
        // A redirect must always proceed, even over a stall.
        pc_write    = flush | ~(lu | hold);
        if_id_write = pc_write;
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, flush, external hold
// and a saturating bubble counter.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc4,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [5:0]            id_funct,
    input  logic [4:0]            id_shamt,
    input  logic                  flush,
    input  logic                  hold,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc4,
    output logic [DATA_W-1:0]     ex_rd1,
    output logic [DATA_W-1:0]     ex_rd2,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [5:0]            ex_funct,
    output logic [4:0]            ex_shamt,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic [CNT_W-1:0]      bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic lu;
    logic id_uses_rt;

    assign id_uses_rt = uses_rt(id_ctrl);

    id_ex_pipe_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
        .ex_rt       (ex_rt),
        .id_valid    (id_valid),
        .id_uses_rt  (id_uses_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .flush       (flush),
        .hold        (hold),
        .lu          (lu),
        .pc_write    (pc_write),
        .if_id_write (if_id_write)
    );

    // Control/valid: reset > flush > hold > bubble > load.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_ctrl  <= CTRL_BUBBLE;
            ex_valid <= 1'b0;
        end else if (flush) begin
            ex_ctrl  <= CTRL_BUBBLE;
            ex_valid <= 1'b0;
        end else if (hold) begin
            ex_ctrl  <= ex_ctrl;
            ex_valid <= ex_valid;
        end else if (lu) begin
            ex_ctrl  <= CTRL_BUBBLE;
            ex_valid <= 1'b0;
        end else begin
            ex_ctrl  <= id_valid ? id_ctrl : CTRL_BUBBLE;
            ex_valid <= id_valid;
        end
    end

    // Datapath fields only move on a real load; flushes and bubbles leave them stale.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_pc4   <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_funct <= '0;
            ex_shamt <= '0;
        end else if (!flush && !hold && !lu) begin
            ex_pc4   <= id_pc4;
            ex_rd1   <= id_rd1;
            ex_rd2   <= id_rd2;
            ex_imm   <= id_imm;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
            ex_funct <= id_funct;
            ex_shamt <= id_shamt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bubble_cnt <= '0;
        end else if (!flush && !hold && lu && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios plus randomized traffic
// against a pipeline-level reference model; a second instance uses a 2-bit counter.
module tb_id_ex_pipe;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RW     = 5;
    localparam int unsigned BUS_W  = 10 + 1 + 4*DATA_W + 3*RW + 6 + 5;

    localparam logic [9:0] C_ADDI = 10'b0000101100;
    localparam logic [9:0] C_LW   = 10'b0100101100;
    localparam logic [9:0] C_RTYP = 10'b1010000100;
    localparam logic [9:0] C_SW   = 10'b0000011000;
    localparam logic [9:0] C_BEQ  = 10'b0001000010;
    localparam logic [9:0] C_J    = 10'b0000000001;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [9:0]        id_ctrl;
    logic              id_valid;
    logic [DATA_W-1:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [RW-1:0]     id_rs, id_rt, id_rd;
    logic [5:0]        id_funct;
    logic [4:0]        id_shamt;
    logic              flush, hold;

    logic [9:0]        ex_ctrl, ex_ctrl2;
    logic              ex_valid, ex_valid2;
    logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [DATA_W-1:0] ex_pc4_2, ex_rd1_2, ex_rd2_2, ex_imm_2;
    logic [RW-1:0]     ex_rs, ex_rt, ex_rd, ex_rs2, ex_rt2, ex_rd2f;
    logic [5:0]        ex_funct, ex_funct2;
    logic [4:0]        ex_shamt, ex_shamt2;
    logic              pc_write, if_id_write, pc_write2, if_id_write2;
    logic [15:0]       bubble_cnt;
    logic [1:0]        bubble_cnt2;

    int checks = 0;
    int errors = 0;

    // Reference model of what EX currently holds.
    logic [9:0]        m_ctrl;
    logic              m_valid;
    logic [DATA_W-1:0] m_pc4, m_rd1, m_rd2, m_imm;
    logic [RW-1:0]     m_rs, m_rt, m_rd;
    logic [5:0]        m_funct;
    logic [4:0]        m_shamt;
    int                m_cnt, m_cnt2;

    always #5 clk = ~clk;

    id_ex_pipe #(.DATA_W(DATA_W), .REG_ADDR_W(RW), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
        .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_shamt(id_shamt),
        .flush(flush), .hold(hold),
        .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1),
        .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_funct(ex_funct), .ex_shamt(ex_shamt),
        .pc_write(pc_write), .if_id_write(if_id_write), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe #(.DATA_W(DATA_W), .REG_ADDR_W(RW), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
        .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_shamt(id_shamt),
        .flush(flush), .hold(hold),
        .ex_ctrl(ex_ctrl2), .ex_valid(ex_valid2), .ex_pc4(ex_pc4_2), .ex_rd1(ex_rd1_2),
        .ex_rd2(ex_rd2_2), .ex_imm(ex_imm_2), .ex_rs(ex_rs2), .ex_rt(ex_rt2), .ex_rd(ex_rd2f),
        .ex_funct(ex_funct2), .ex_shamt(ex_shamt2),
        .pc_write(pc_write2), .if_id_write(if_id_write2), .bubble_cnt(bubble_cnt2)
    );

    wire [BUS_W-1:0] dut_bus = {ex_ctrl, ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm,
                                ex_rs, ex_rt, ex_rd, ex_funct, ex_shamt};
    wire [BUS_W-1:0] sat_bus = {ex_ctrl2, ex_valid2, ex_pc4_2, ex_rd1_2, ex_rd2_2, ex_imm_2,
                                ex_rs2, ex_rt2, ex_rd2f, ex_funct2, ex_shamt2};

    function automatic logic [BUS_W-1:0] model_bus();
        return {m_ctrl, m_valid, m_pc4, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd, m_funct, m_shamt};
    endfunction

    // A load sitting in EX whose target is read by the ID instruction (never $0).
    function automatic bit model_lu();
        bit ex_is_load;
        bit id_reads_rt;
        ex_is_load  = m_valid && m_ctrl[5];
        id_reads_rt = id_ctrl[9] || id_ctrl[4] || id_ctrl[1];
        return ex_is_load && (m_rt != 0) && id_valid &&
               ((id_rs == m_rt) || (id_reads_rt && id_rt == m_rt));
    endfunction

    function automatic bit model_front_en();
        return flush || !(hold || model_lu());
    endfunction

    // One clock edge: the model advances from the same inputs the DUT sees.
    task automatic tick();
        bit lu_now;
        lu_now = model_lu();
        @(posedge clk);
        if (!reset_n) begin
            m_ctrl = '0; m_valid = 0; m_pc4 = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
            m_rs = '0; m_rt = '0; m_rd = '0; m_funct = '0; m_shamt = '0;
            m_cnt = 0; m_cnt2 = 0;
        end else if (flush) begin
            m_ctrl = '0; m_valid = 0;
        end else if (hold) begin
            // frozen
        end else if (lu_now) begin
            m_ctrl = '0; m_valid = 0;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end else begin
            m_ctrl = id_valid ? id_ctrl : 10'b0; m_valid = id_valid;
            m_pc4 = id_pc4; m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_funct = id_funct; m_shamt = id_shamt;
        end
        #1;
    endtask

    task automatic drive(input logic [9:0] ctrl, input logic v,
                         input logic [RW-1:0] rs, input logic [RW-1:0] rt);
        id_ctrl = ctrl; id_valid = v; id_rs = rs; id_rt = rt;
        id_rd = RW'($urandom); id_pc4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom;
        id_imm = $urandom; id_funct = 6'($urandom); id_shamt = 5'($urandom);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0; flush = 0; hold = 0;
        drive(C_LW, 1, 5'd1, 5'd2);
        tick(); tick();
        checks++;
        if (dut_bus !== '0) begin
            errors++; $display("FAIL reset_bus got=%h exp=0", dut_bus);
        end
        checks++;
        if (bubble_cnt !== 16'd0 || bubble_cnt2 !== 2'd0 || ex_valid2 !== 1'b0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bubble_cnt, bubble_cnt2);
        end
        reset_n = 1;
    endtask

    task automatic test_addi();
        drive(C_ADDI, 1, 5'd3, 5'd4);
        id_imm = 32'd5; #1;
        checks++;
        if (pc_write !== 1'b1) begin
            errors++; $display("FAIL addi_pc_write got=%b exp=1", pc_write);
        end
        tick();
        checks++;
        if (ex_ctrl !== C_ADDI || ex_imm !== 32'd5 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL addi_ex got ctrl=%b imm=%0d v=%b exp ctrl=%b imm=5 v=1",
                               ex_ctrl, ex_imm, ex_valid, C_ADDI);
        end
        checks++;
        if (dut_bus !== model_bus()) begin
            errors++; $display("FAIL addi_bus got=%h exp=%h", dut_bus, model_bus());
        end
        checks++;
        if (pc_write !== 1'b1) begin
            errors++; $display("FAIL addi_pc_write_after got=%b exp=1", pc_write);
        end
    endtask

    task automatic test_load_use();
        drive(C_LW, 1, 5'd2, 5'd8);
        tick();
        drive(C_RTYP, 1, 5'd8, 5'd9);
        checks++;
        if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin
            errors++; $display("FAIL lu_stall got pc=%b ifid=%b exp 0/0", pc_write, if_id_write);
        end
        tick();
        checks++;
        if (ex_ctrl !== 10'b0 || ex_valid !== 1'b0 || bubble_cnt !== 16'd1) begin
            errors++; $display("FAIL lu_bubble got ctrl=%b v=%b cnt=%0d exp 0/0/1",
                               ex_ctrl, ex_valid, bubble_cnt);
        end
        checks++;
        if (pc_write !== 1'b1) begin
            errors++; $display("FAIL lu_release got=%b exp=1", pc_write);
        end
        tick();
        checks++;
        if (ex_ctrl !== C_RTYP || ex_valid !== 1'b1 || ex_rs !== 5'd8 || dut_bus !== model_bus()) begin
            errors++; $display("FAIL lu_add_enters got=%h exp=%h", dut_bus, model_bus());
        end
    endtask

    task automatic test_zero_reg();
        drive(C_LW, 1, 5'd1, 5'd0);
        tick();
        drive(C_RTYP, 1, 5'd0, 5'd0);
        checks++;
        if (pc_write !== 1'b1) begin
            errors++; $display("FAIL zero_reg_stall got=%b exp=1", pc_write);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_ctrl !== C_RTYP || bubble_cnt !== 16'd1) begin
            errors++; $display("FAIL zero_reg_noop got v=%b ctrl=%b cnt=%0d exp 1/%b/1",
                               ex_valid, ex_ctrl, bubble_cnt, C_RTYP);
        end
    endtask

    task automatic test_flush_hold();
        drive(C_LW, 1, 5'd1, 5'd5);
        tick();
        drive(C_BEQ, 1, 5'd5, 5'd6);
        flush = 1; hold = 1; #1;
        checks++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            errors++; $display("FAIL flush_en got pc=%b ifid=%b exp 1/1", pc_write, if_id_write);
        end
        tick();
        flush = 0; hold = 0;
        checks++;
        if (ex_ctrl !== 10'b0 || ex_valid !== 1'b0 || bubble_cnt !== 16'd1 || dut_bus !== model_bus()) begin
            errors++; $display("FAIL flush_beats_hold got=%h cnt=%0d exp=%h cnt=1",
                               dut_bus, bubble_cnt, model_bus());
        end
    endtask

    task automatic test_hold();
        drive(C_SW, 1, 5'd7, 5'd3);
        tick();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            drive(i == 1 ? C_J : C_ADDI, 1, RW'($urandom), RW'($urandom));
            checks++;
            if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin
                errors++; $display("FAIL hold_en[%0d] got pc=%b ifid=%b exp 0/0", i, pc_write, if_id_write);
            end
            tick();
            checks++;
            if (ex_ctrl !== C_SW || dut_bus !== model_bus() || bubble_cnt !== 16'd1) begin
                errors++; $display("FAIL hold_frozen[%0d] got=%h cnt=%0d exp=%h cnt=1",
                                   i, dut_bus, bubble_cnt, model_bus());
            end
        end
        hold = 0;
    endtask

    task automatic test_saturation();
        int exp2 [5] = '{1, 2, 3, 3, 3};
        reset_n = 0; drive(10'b0, 0, 5'd0, 5'd0); tick(); reset_n = 1;
        for (int i = 0; i < 5; i++) begin
            drive(C_LW, 1, 5'd1, 5'd10);
            tick();
            drive(C_SW, 1, 5'd2, 5'd10);
            tick();
            checks++;
            if (int'(bubble_cnt2) != exp2[i] || int'(bubble_cnt) != i + 1) begin
                errors++; $display("FAIL sat_cnt[%0d] got=%0d/%0d exp=%0d/%0d",
                                   i, bubble_cnt2, bubble_cnt, exp2[i], i + 1);
            end
            tick();
        end
        drive(C_LW, 1, 5'd1, 5'd11);
        tick();
        drive(C_RTYP, 1, 5'd11, 5'd0);
        reset_n = 0; #1;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || bubble_cnt !== 16'd0 || bubble_cnt2 !== 2'd0) begin
            errors++; $display("FAIL reset_mid_stall got v=%b cnt=%0d/%0d exp 0/0/0",
                               ex_valid, bubble_cnt, bubble_cnt2);
        end
        reset_n = 1; #1;
        checks++;
        if (pc_write !== 1'b1) begin
            errors++; $display("FAIL reset_no_pending got=%b exp=1", pc_write);
        end
        tick();
    endtask

    task automatic test_random();
        logic [9:0] kinds [6] = '{C_ADDI, C_LW, C_RTYP, C_SW, C_BEQ, C_J};
        for (int i = 0; i < 400; i++) begin
            drive(kinds[$urandom_range(0, 5)], ($urandom_range(0, 99) < 85),
                  RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)));
            flush   = ($urandom_range(0, 99) < 8);
            hold    = ($urandom_range(0, 99) < 15);
            reset_n = ($urandom_range(0, 99) >= 2);
            #1;
            checks++;
            if (pc_write !== model_front_en() || if_id_write !== model_front_en()) begin
                errors++; $display("FAIL rand_en[%0d] got pc=%b ifid=%b exp=%b",
                                   i, pc_write, if_id_write, model_front_en());
            end
            tick();
            checks++;
            if (dut_bus !== model_bus() || sat_bus !== model_bus() ||
                int'(bubble_cnt) != m_cnt || int'(bubble_cnt2) != m_cnt2) begin
                errors++; $display("FAIL rand_state[%0d] got=%h cnt=%0d/%0d exp=%h cnt=%0d/%0d",
                                   i, dut_bus, bubble_cnt, bubble_cnt2, model_bus(), m_cnt, m_cnt2);
            end
        end
        flush = 0; hold = 0; reset_n = 1;
    endtask

    initial begin
        reset_n = 0; flush = 0; hold = 0;
        drive(10'b0, 0, 5'd0, 5'd0);
        test_reset();
        test_addi();
        test_load_use();
        test_zero_reg();
        test_flush_hold();
        test_hold();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline stage of the 5-stage MIPS core. It sits directly downstream of the opcode decoder.
- Latches the decoder's control bundle together with the ID-stage datapath operands, and presents them to EX one cycle later.
- Contains load-use hazard detection. On a hazard it freezes PC and IF/ID, and inserts a bubble.
- Also handles flushes on taken branch/jump and external holds (e.g. multi-cycle mult/div), and counts inserted bubbles for performance monitoring.

Parameters:
- DATA_W, 32, datapath width (register read data, sign-extended immediate, PC+4).
- REG_ADDR_W, 5, register specifier width.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- id_ctrl  in  10  decoder control bundle. Bit order: [9]reg_dst [8]mem_to_reg [7:6]alu_op [5]mem_read [4]mem_write [3]alu_src [2]reg_write [1]branch [0]jump.
- id_valid  in  1  the IF/ID register holds a real instruction.
- id_pc4  in  DATA_W  PC+4 of the ID instruction.
- id_rd1, id_rd2  in  DATA_W  register file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- id_rs, id_rt, id_rd  in  REG_ADDR_W  instruction fields [25:21], [20:16], [15:11].
- id_funct  in  6  instruction[5:0].
- id_shamt  in  5  instruction[10:6].
- flush  in  1  taken branch/jump resolved this cycle.
- hold  in  1  external EX stall.
- ex_ctrl  out  10  registered control bundle.
- ex_valid  out  1  registered valid.
- ex_pc4, ex_rd1, ex_rd2, ex_imm  out  DATA_W  registered operands.
- ex_rs, ex_rt, ex_rd  out  REG_ADDR_W  registered register specifiers.
- ex_funct  out  6  registered funct field.
- ex_shamt  out  5  registered shamt field.
- pc_write  out  1  PC update enable (combinational).
- if_id_write  out  1  IF/ID update enable (combinational).
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted.

Behaviour:
- Reset (reset_n=0 at a clk edge): all ex_* outputs are 0, ex_valid=0, and bubble_cnt=0. Reset has priority over every other input.
- Load-use hazard (combinational), `lu` is asserted when all of the following hold:
  - ex_valid and ex_ctrl[5] (mem_read);
  - ex_rt != 0;
  - id_valid;
  - ex_rt == id_rs, or ex_rt == id_rt where ID uses rt (id_ctrl[9] | id_ctrl[4] | id_ctrl[1]).
- Enables: pc_write = if_id_write = ~(lu | hold). When flush=1, the enables are forced to 1 regardless of lu/hold, so redirect always proceeds.
- Register update priority at each clk edge, with reset_n=1:
  1. flush: ex_ctrl=0, ex_valid=0, datapath fields unchanged. Flush beats hold.
  2. hold: every ex_* register keeps its value. No bubble is counted.
  3. lu: bubble. ex_ctrl=0, ex_valid=0, datapath fields unchanged, bubble_cnt += 1.
  4. Otherwise, load: ex_ctrl=id_ctrl gated by id_valid (all zero when id_valid=0), ex_valid=id_valid, all datapath fields captured.
- Latency: exactly 1 cycle from ID inputs to ex_* outputs.
- A bubble's control fields are all zero. It therefore performs no register write, memory access, branch or jump.
- Stall duration: one bubble per load-use. On the next cycle the load is in MEM, ex_mem_read refers to the bubble (ex_valid=0), so lu deasserts automatically.
- bubble_cnt saturates at all-ones and does not wrap.
- hold and lu together: hold wins. The registers are frozen and the hazard is re-evaluated on the next cycle.
- Reset mid-stall: the next cycle starts clean, with ex_valid=0 and no pending hazard.

Decomposition:
- Shared package holds:
  - CTRL_W=10 and the control bit index constants (CTRL_REG_DST ... CTRL_JUMP);
  - CTRL_BUBBLE=10'b0;
  - the opcode constants already used by the decoder.
- One sub-module, hazard_detect: combinational `lu` equation plus the pc_write/if_id_write generation.
- Pipeline registers and bubble counter live in id_ex_pipe.

Test Plan:
1. Reset, then addi (id_ctrl=10'b0000101100, id_imm=5, id_valid=1) for 1 cycle -> ex_ctrl=10'b0000101100, ex_imm=5, ex_valid=1 one cycle later; pc_write=1 throughout.
2. lw (id_rt=8) followed by R-type add with id_rs=8 -> for 1 cycle pc_write=if_id_write=0, next ex_ctrl=0, ex_valid=0, bubble_cnt=1; add then enters EX on the following cycle.
3. lw with id_rt=0 followed by an R-type reading $0 -> no stall, bubble_cnt stays 0.
4. flush=1 while hold=1 and a valid beq in ID -> ex_ctrl=0, ex_valid=0 next cycle; pc_write=1.
5. hold=1 for 3 cycles with a valid sw in EX -> ex_* unchanged for 3 cycles, bubble_cnt unchanged, pc_write=0.
6. CNT_W=2, 5 back-to-back load-use pairs -> bubble_cnt reads 1,2,3,3,3 (saturates); reset_n=0 mid-sequence -> bubble_cnt=0, ex_valid=0.
